// File: rtl/sink_checker_if.sv
// valid_ready: point-to-point handshake bus between a word source and a sink.
//   data  - payload word, DATA_WIDTH bits, driven by the Master
//   valid - Master has a word on data
//   ready - Slave can take a word this cycle
// A word transfers on a rising clock edge where valid && ready.
interface valid_ready #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport Master (output data, output valid, input ready);
  modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/sink_checker.sv
// sink_checker: receiving end of a valid_ready bus. It consumes words from an
// incrementing source, applies programmable backpressure (ready stays low for
// 'delay' cycles after each accepted word), checks the data is a +1 sequence,
// and counts accepted words and sequence errors.
//
// Ports:
//   clk       - clock, all state on the rising edge
//   reset     - asynchronous, active-high
//   delay     - backpressure cycles between handshakes; 0 keeps ready high
//   vrBus     - valid_ready.Slave: data/valid in, ready out
//   last_data - last accepted word
//   rx_count  - accepted-word count, wraps
//   err_count - sequence-error count, saturates at all-ones
//   err_pulse - high for one cycle after a handshake that carried a bad word
//
// Build option: define SINK_LFSR_STALL_EN to add pseudo-random extra stalls
// from an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5) that masks ready.
module sink_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DELAY_BITS = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DELAY_BITS-1:0] delay,
  valid_ready.Slave             vrBus,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_pulse
);

  typedef enum logic [1:0] {
    StHoldOff = 2'b00,
    StAccept  = 2'b01
  } state_e;

  state_e                state_q;
  logic                  ready_q;
  logic [DELAY_BITS-1:0] delay_count_q;
  logic [DATA_WIDTH-1:0] expected_q;

  logic                  ready_eff;
  logic                  handshake;
  logic [DELAY_BITS:0]   count_inc;

  // One extra bit so the compare cannot wrap when delay is at its maximum.
  assign count_inc = {1'b0, delay_count_q} + (DELAY_BITS + 1)'(1);

`ifdef SINK_LFSR_STALL_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Extra stall whenever the LFSR low bit is set; the handshake uses the gated ready.
  assign ready_eff = ready_q & ~lfsr_q[0];
`else
  assign ready_eff = ready_q;
`endif

  assign vrBus.ready = ready_eff;
  assign handshake   = vrBus.valid & ready_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StHoldOff;
      ready_q       <= 1'b0;
      delay_count_q <= '0;
      expected_q    <= DATA_WIDTH'(1);
      last_data     <= '0;
      rx_count      <= '0;
      err_count     <= '0;
      err_pulse     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state_q)
        StHoldOff: begin
          delay_count_q <= delay_count_q + DELAY_BITS'(1);
          // >= rather than == so lowering delay mid-count still releases ready.
          if (delay == '0 || count_inc >= {1'b0, delay}) begin
            ready_q <= 1'b1;
            state_q <= StAccept;
          end
        end
        StAccept: begin
          if (handshake) begin
            last_data <= vrBus.data;
            rx_count  <= rx_count + CNT_WIDTH'(1);
            if (vrBus.data != expected_q) begin
              if (err_count != '1) begin
                err_count <= err_count + CNT_WIDTH'(1);
              end
              err_pulse <= 1'b1;
            end
            // Resync on the received word so a single bad word costs one error.
            expected_q <= vrBus.data + DATA_WIDTH'(1);
            if (delay != '0) begin
              ready_q       <= 1'b0;
              delay_count_q <= '0;
              state_q       <= StHoldOff;
            end
          end
        end
        default: begin
          ready_q       <= 1'b0;
          delay_count_q <= '0;
          state_q       <= StHoldOff;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sink_checker.sv
module tb_sink_checker;

  logic       clk;
  logic       reset;
  logic [2:0] delay;
  logic [7:0] last_data;
  logic [15:0] rx_count;
  logic [15:0] err_count;
  logic       err_pulse;

  valid_ready #(.DATA_WIDTH(8)) vr_bus ();

  sink_checker #(
    .DATA_WIDTH(8),
    .DELAY_BITS(3),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .delay    (delay),
    .vrBus    (vr_bus),
    .last_data(last_data),
    .rx_count (rx_count),
    .err_count(err_count),
    .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: ready is low for max(delay,1) edges after each handshake
  // (or after reset); every accepted word is compared with last accepted + 1.
  bit m_ready;
  bit m_waiting;   // inside the post-handshake gap
  int m_gap;       // edges spent in the current gap
  int m_expected;
  int m_last;
  int m_rx;
  int m_err;
  bit m_pulse;
  bit m_hs;
  int m_lfsr;
  int stalls;

  function automatic bit m_ready_eff();
`ifdef SINK_LFSR_STALL_EN
    return m_ready && (m_lfsr % 2 == 0);
`else
    return m_ready;
`endif
  endfunction

  task automatic model_reset();
    m_ready    = 0;
    m_waiting  = 1;
    m_gap      = 0;
    m_expected = 1;
    m_last     = 0;
    m_rx       = 0;
    m_err      = 0;
    m_pulse    = 0;
    m_hs       = 0;
    m_lfsr     = 8'hA5;
  endtask

  task automatic model_step(input bit v, input int d, input int dl);
    int fb;
    m_hs    = v && m_ready_eff();
    m_pulse = 0;
    if (m_waiting) begin
      if (dl == 0 || m_gap + 1 >= dl) begin
        m_ready   = 1;
        m_waiting = 0;
      end
      m_gap++;
    end else if (m_hs) begin
      m_last = d;
      m_rx   = (m_rx + 1) % 65536;
      if (d != m_expected) begin
        if (m_err < 65535) m_err++;
        m_pulse = 1;
      end
      m_expected = (d + 1) % 256;
      if (dl != 0) begin
        m_ready   = 0;
        m_waiting = 1;
        m_gap     = 0;
      end
    end
    fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 8'hFF;
  endtask

  task automatic check_outputs();
    check_eq("ready", {31'd0, vr_bus.ready}, {31'd0, m_ready_eff()});
    check_eq("last_data", {24'd0, last_data}, m_last);
    check_eq("rx_count", {16'd0, rx_count}, m_rx);
    check_eq("err_count", {16'd0, err_count}, m_err);
    check_eq("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
  endtask

  bit dut_hs;

  // Called at a falling edge: drive inputs, advance one clock, check.
  task automatic step(input bit v, input logic [7:0] d, input logic [2:0] dl);
    vr_bus.valid = v;
    vr_bus.data  = d;
    delay        = dl;
    #1;
    dut_hs = v && vr_bus.ready;
    if (!vr_bus.ready) stalls++;
    @(posedge clk);
    model_step(v, int'(d), int'(dl));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [7:0] w, input logic [2:0] dl);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, w, dl);
      if (m_hs) return;
    end
    check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, {31'd0, vr_bus.ready}, 32'd0);
    check_eq({tag, "_last"}, {24'd0, last_data}, 32'd0);
    check_eq({tag, "_rx"}, {16'd0, rx_count}, 32'd0);
    check_eq({tag, "_err"}, {16'd0, err_count}, 32'd0);
    check_eq({tag, "_pulse"}, {31'd0, err_pulse}, 32'd0);
  endtask

  // Asserted between edges (asynchronous), held across one rising edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset_values({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    check_reset_values({tag, "_held"});
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int err_before;
    int cur;
    logic [2:0] dl;
    logic [7:0] d;
    bit v;

    reset        = 1'b1;
    vr_bus.valid = 1'b0;
    vr_bus.data  = '0;
    delay        = '0;
    stalls       = 0;
    model_reset();
    @(negedge clk);
    do_reset("rst");

    // 1: delay 0, stream 1,2,3
    for (int w = 1; w <= 3; w++) send_word(8'(w), 3'd0);
    check_eq("t1_rx", {16'd0, rx_count}, 32'd3);
    check_eq("t1_last", {24'd0, last_data}, 32'd3);
    check_eq("t1_err", {16'd0, err_count}, 32'd0);

    // 2: delay 3 with valid always high
    hs_cnt = 0;
    cur    = 4;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(cur), 3'd3);
      if (dut_hs) hs_cnt++;
      if (m_hs) cur++;
    end
`ifndef SINK_LFSR_STALL_EN
    check_eq("t2_hs_per_12", hs_cnt, 32'd3);
`endif

    // 3: 1,2,5,6 -> one error at 5
    @(negedge clk);
    do_reset("rst3");
    send_word(8'd1, 3'd1);
    send_word(8'd2, 3'd1);
    send_word(8'd5, 3'd1);
    check_eq("t3_pulse", {31'd0, err_pulse}, 32'd1);
    send_word(8'd6, 3'd1);
    check_eq("t3_err", {16'd0, err_count}, 32'd1);
    check_eq("t3_pulse_clr", {31'd0, err_pulse}, 32'd0);

    // 4: 254,255,0,1 -> only the jump to 254 is an error
    send_word(8'd254, 3'd2);
    err_before = int'(err_count);
    check_eq("t4_err_resync", err_before, 32'd2);
    send_word(8'd255, 3'd2);
    send_word(8'd0, 3'd2);
    send_word(8'd1, 3'd2);
    check_eq("t4_err_wrap", {16'd0, err_count}, err_before);
    check_eq("t4_last", {24'd0, last_data}, 32'd1);

    // 5: reset while accepting with valid high
    send_word(8'd2, 3'd0);
    step(1'b1, 8'd3, 3'd0);
    vr_bus.valid = 1'b1;
    do_reset("rst5");
    send_word(8'd1, 3'd0);
    check_eq("t5_err", {16'd0, err_count}, 32'd0);
    check_eq("t5_rx", {16'd0, rx_count}, 32'd1);

    // Random traffic, occasional bad words and live delay changes.
    cur = 2;
    dl  = 3'd1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) dl = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(0, 255)) : 8'(cur);
      step(v, d, dl);
      if (m_hs) cur = (int'(d) + 1) % 256;
    end

`ifdef SINK_LFSR_STALL_EN
    // 6: LFSR stalls with delay 0
    @(negedge clk);
    do_reset("rst6");
    stalls = 0;
    for (int w = 1; w <= 200; w++) send_word(8'(w % 256), 3'd0);
    check_eq("t6_rx", {16'd0, rx_count}, 32'd200);
    check_eq("t6_err", {16'd0, err_count}, 32'd0);
    check_eq("t6_stalls_seen", {31'd0, stalls > 1}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
